hlsm_job_driver: RTL

//  Initiator side of the HLSM Start/Done handshake. Collects one job as 9 serial

---
 rtl/hlsm_job_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hlsm_job_driver.sv
// rtl/hlsm_job_driver.sv - initiator side of the HLSM Start/Done handshake
//
// Collects one job as 9 serial operand beats (a..h, then sa) and holds them on
// op_*. It then pulses Start for one cycle and waits for Done. When Done arrives
// it captures avg_in and returns it on a valid/ready result stream. If Done
// never arrives, a timeout aborts the job and returns res_data=0 with
// res_timeout=1.
//
// Ports:
//   Clk, Rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready/in_data operand beat stream, order a,b,c,d,e,f,g,h,sa
//   Start, Done, avg_in       HLSM handshake and result
//   op_a..op_h, op_sa         held operands, stable from Start through result
//   res_valid/res_ready       result stream
//   res_data, res_timeout     result value and its abort qualifier
//   busy                      high whenever a job is in flight (not LOAD)
//   proto_err                 sticky: Done observed outside WAIT_DONE
module hlsm_job_driver #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             Start,
    input  logic             Done,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic [WIDTH-1:0] op_e,
    output logic [WIDTH-1:0] op_f,
    output logic [WIDTH-1:0] op_g,
    output logic [WIDTH-1:0] op_h,
    output logic [WIDTH-1:0] op_sa,
    input  logic [WIDTH-1:0] avg_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_timeout,
    output logic             busy,
    output logic             proto_err
);

    localparam int            TW    = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       beat;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] ops [9];

    assign op_a  = ops[0];
    assign op_b  = ops[1];
    assign op_c  = ops[2];
    assign op_d  = ops[3];
    assign op_e  = ops[4];
    assign op_f  = ops[5];
    assign op_g  = ops[6];
    assign op_h  = ops[7];
    assign op_sa = ops[8];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= LOAD;
            beat        <= '0;
            timer       <= '0;
            in_ready    <= 1'b0;
            Start       <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
            proto_err   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                ops[i] <= '0;
            end
        end else begin
            // The HLSM has no reset of its own, so a Done can show up at any
            // time; outside WAIT_DONE it is flagged and otherwise ignored.
            if (Done && state != WAIT_DONE) begin
                proto_err <= 1'b1;
            end

            case (state)
                LOAD: begin
                    // Registered ready: stays low for the first cycle after reset.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        ops[beat] <= in_data;
                        if (beat == 4'd8) begin
                            beat     <= '0;
                            in_ready <= 1'b0;
                            Start    <= 1'b1;
                            busy     <= 1'b1;
                            state    <= START;
                        end else begin
                            beat <= beat + 4'd1;
                        end
                    end
                end

                START: begin
                    Start <= 1'b0;
                    timer <= '0;
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    // The timer leaves this state at TLAST, so it cannot wrap.
                    timer <= timer + TW'(1);
                    if (Done) begin
                        res_data    <= avg_in;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (timer == TLAST) begin
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= LOAD;
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule
